// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Read data returned to a requester whose access was aborted by the watchdog.
  localparam logic [31:0] ARB_ERR_RDATA = '0;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: counts cycles spent waiting for mem_ack and flags expiry
// once the count reaches TIMEOUT-1.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_cnt == CW'(TIMEOUT - 1));
  assign o_expired = w_expired;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory-controller port between instruction fetch and
// data access. Optional performance counters are enabled with ARB_PERF_CNT_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          acc_err,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]   perf_if_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_timeouts,
`endif
  input  logic          mem_ack
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    r_state;
  logic [SW-1:0] r_streak;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_valid;
  logic          r_d_valid;
  logic          r_acc_err;
  logic          r_mem_req;
  logic          r_mem_wr;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_waiting;
  logic          w_expired;
  logic          w_fetch_forced;
  logic          w_d_grant;
  logic          w_i_grant;
  logic          w_finish;
  logic [DW-1:0] w_done_rdata;

  assign w_waiting      = (r_state == WAIT_I) || (r_state == WAIT_D);
  assign w_fetch_forced = if_req && (r_streak == SW'(MAX_D_STREAK));
  assign w_d_grant      = (r_state == IDLE) && d_req && !w_fetch_forced;
  assign w_i_grant      = (r_state == IDLE) && !w_d_grant && if_req;
  // An ack in the expiry cycle completes normally.
  assign w_finish       = w_waiting && (mem_ack || w_expired);
  assign w_done_rdata   = mem_ack ? mem_rdata : DW'(ARB_ERR_RDATA);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (!w_waiting),
    .i_en      (w_waiting),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_acc_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_acc_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_grant) begin
            r_state     <= WAIT_D;
            r_mem_req   <= 1'b1;
            r_mem_wr    <= d_wr;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (!if_req) begin
              r_streak <= '0;
            end else if (r_streak != SW'(MAX_D_STREAK)) begin
              r_streak <= r_streak + 1'b1;
            end
          end else if (w_i_grant) begin
            r_state    <= WAIT_I;
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= if_addr;
            r_streak   <= '0;
          end
        end
        WAIT_I, WAIT_D: begin
          if (w_finish) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_acc_err <= !mem_ack;
            if (r_state == WAIT_I) begin
              r_if_rdata <= w_done_rdata;
              r_if_valid <= 1'b1;
            end else begin
              r_d_rdata <= w_done_rdata;
              r_d_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_if <= '0;
      r_perf_d  <= '0;
      r_perf_to <= '0;
    end else begin
      if (w_i_grant) r_perf_if <= r_perf_if + 1'b1;
      if (w_d_grant) r_perf_d  <= r_perf_d + 1'b1;
      if (w_finish && !mem_ack) r_perf_to <= r_perf_to + 1'b1;
    end
  end

  assign perf_if_grants = r_perf_if;
  assign perf_d_grants  = r_perf_d;
  assign perf_timeouts  = r_perf_to;
`endif

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign acc_err   = r_acc_err;
  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a request-level arbitration model and a memory responder.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        acc_err;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_timeouts;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_D_STREAK (MAXS),
    .TIMEOUT      (TO),
    .AW           (32),
    .DW           (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .acc_err   (acc_err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_timeouts  (perf_timeouts),
`endif
    .mem_ack   (mem_ack)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Expected responses: 1 = fetch, 2 = data
  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        err;
    int unsigned at;
  } resp_t;

  resp_t exp_q[$];
  int    order_q[$];

  // Request-level arbitration model
  bit          model_en    = 1'b0;
  bit          m_idle_next = 1'b1;
  int          m_streak    = 0;
  bit          g_pend      = 1'b0;
  int          cur_who     = 0;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_wr;

  always @(negedge clk) begin : model
    bit idle;
    bit forced;
    if (model_en && !rst) begin
      idle = m_idle_next;
      m_idle_next = 1'b0;
      if (g_pend) begin
        chk("grant_req", 64'(mem_req), 64'd1);
        chk("grant_addr", 64'(mem_addr), 64'(g_addr));
        chk("grant_wr", 64'(mem_wr), 64'(g_wr));
        if (g_wr) chk("grant_wdata", 64'(mem_wdata), 64'(g_wdata));
        g_pend = 1'b0;
      end
      if (idle) begin
        forced = if_req && (m_streak >= int'(MAXS));
        if (d_req && !forced) begin
          cur_who  = 2;
          g_addr   = d_addr;
          g_wr     = d_wr;
          g_wdata  = d_wdata;
          m_streak = if_req ? m_streak + 1 : 0;
          g_pend   = 1'b1;
        end else if (if_req) begin
          cur_who  = 1;
          g_addr   = if_addr;
          g_wr     = 1'b0;
          m_streak = 0;
          g_pend   = 1'b1;
        end else begin
          chk("idle_no_req", 64'(mem_req), 64'd0);
          m_idle_next = 1'b1;
        end
        if (g_pend) order_q.push_back(cur_who);
      end
      if (if_valid || d_valid) m_idle_next = 1'b1;
    end
  end

  // Memory responder: schedules acks (or withholds them) and records the expected response
  bit          resp_en    = 1'b1;
  bit          use_force  = 1'b0;
  bit          f_hang     = 1'b0;
  int          f_dly      = 0;
  logic [31:0] f_rdata    = '0;
  bit          stray_pend = 1'b0;

  initial begin : responder
    bit          active;
    bit          acked;
    bit          hang;
    int          dly;
    logic [31:0] rd;
    active = 1'b0;
    acked  = 1'b0;
    hang   = 1'b0;
    dly    = 0;
    rd     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!mem_req) active = 1'b0;
      if (stray_pend) begin
        mem_ack    = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        stray_pend = 1'b0;
      end else if (resp_en && mem_req && !active) begin
        active = 1'b1;
        acked  = 1'b0;
        hang   = use_force ? f_hang : ($urandom_range(0, 39) == 0);
        dly    = use_force ? f_dly : int'($urandom_range(0, 4));
        rd     = use_force ? f_rdata : $urandom;
        if (hang) exp_q.push_back('{cur_who, 32'h0, 1'b1, cyc + TO});
        else      exp_q.push_back('{cur_who, rd, 1'b0, cyc + dly + 1});
      end
      if (resp_en && active && !hang && !acked) begin
        if (dly == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
          acked     = 1'b1;
        end else begin
          dly--;
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    resp_t e;
    int    who;
    if (!rst) begin
      if (acc_err && !if_valid && !d_valid) fail("err_without_valid");
      if (if_valid || d_valid) begin
        chk("one_valid", 64'(if_valid && d_valid), 64'd0);
        chk("req_low_done", 64'(mem_req), 64'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          e   = exp_q.pop_front();
          who = if_valid ? 1 : 2;
          chk("resp_who", 64'(who), 64'(e.who));
          chk("resp_rdata", 64'(if_valid ? if_rdata : d_rdata), 64'(e.rdata));
          chk("resp_err", 64'(acc_err), 64'(e.err));
          chk("resp_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  int if_wait = 0;
  int d_wait  = 0;

  task automatic rand_step(bit allow_new);
    if (if_req) begin
      if (if_valid) begin
        if_wait = 0;
        if (allow_new && $urandom_range(0, 1) == 1) if_addr = $urandom;
        else if_req = 1'b0;
      end else if (++if_wait == 2000) fail("if_starved");
    end else if (allow_new && $urandom_range(0, 3) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom;
    end
    if (d_req) begin
      if (d_valid) begin
        d_wait = 0;
        if (allow_new && $urandom_range(0, 1) == 1) begin
          d_wr    = $urandom_range(0, 1) == 1;
          d_addr  = $urandom;
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if (++d_wait == 2000) fail("d_starved");
    end else if (allow_new && $urandom_range(0, 2) == 0) begin
      d_req   = 1'b1;
      d_wr    = $urandom_range(0, 1) == 1;
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
  endtask

  task automatic wait_valid(bit is_if, string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = is_if ? if_valid : d_valid;
    end
    if (!seen) fail(nm);
  endtask

  task automatic wait_mem_req(string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = mem_req;
    end
    if (!seen) fail(nm);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int nvalid;
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_valids", 64'({if_valid, d_valid, acc_err}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    rst         = 1'b0;
    m_idle_next = 1'b1;
    m_streak    = 0;
    model_en    = 1'b1;

    // Single load, ack three cycles after the request is seen
    use_force = 1'b1;
    f_hang    = 1'b0;
    f_dly     = 2;
    f_rdata   = 32'hCAFE_F00D;
    d_wr      = 1'b0;
    d_addr    = 32'h100;
    d_req     = 1'b1;
    wait_valid(1'b0, "t1_d_valid");
    chk("t1_rdata", 64'(d_rdata), 64'hCAFE_F00D);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous requests: data first, then fetch
    order_q.delete();
    f_dly   = 1;
    f_rdata = 32'h1234_5678;
    d_addr  = 32'h200;
    if_addr = 32'h300;
    d_req   = 1'b1;
    if_req  = 1'b1;
    for (int i = 0; i < 300 && (d_req || if_req); i++) begin
      @(posedge clk);
      #1;
      if (d_valid) d_req = 1'b0;
      if (if_valid) if_req = 1'b0;
    end
    chk("t2_grants", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      chk("t2_first", 64'(order_q[0]), 64'd2);
      chk("t2_second", 64'(order_q[1]), 64'd1);
    end
    repeat (2) @(posedge clk);
    #1;

    // Streak limit: continuous data traffic with fetch pending
    order_q.delete();
    f_dly   = 0;
    d_addr  = 32'h400;
    if_addr = 32'h800;
    d_req   = 1'b1;
    if_req  = 1'b1;
    for (int i = 0; i < 600 && order_q.size() < 6; i++) begin
      @(posedge clk);
      #1;
      if (d_valid) d_addr = d_addr + 32'd4;
      if (if_valid) if_req = 1'b0;
    end
    wait_valid(1'b0, "t3_last_valid");
    d_req = 1'b0;
    chk("t3_grants", 64'(order_q.size()), 64'd6);
    if (order_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", 64'(order_q[i]), (i == 4) ? 64'd1 : 64'd2);
    end
    repeat (2) @(posedge clk);
    #1;

    // Hung access: watchdog abort, then a late stray ack
    f_hang = 1'b1;
    d_wr   = 1'b0;
    d_addr = 32'h440;
    d_req  = 1'b1;
    wait_valid(1'b0, "t4_d_valid");
    chk("t4_err", 64'(acc_err), 64'd1);
    chk("t4_rdata", 64'(d_rdata), 64'd0);
    d_req = 1'b0;
    repeat (5) @(posedge clk);
    stray_pend = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_stray_req", 64'(mem_req), 64'd0);
    f_hang = 1'b0;

    // Store: write qualifier and data held until ack
    f_dly   = 3;
    f_rdata = 32'h0;
    d_wr    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h55;
    d_req   = 1'b1;
    wait_mem_req("t5_mem_req");
    for (int i = 0; i < 3; i++) begin
      chk("t5_mem_wr", 64'(mem_wr), 64'd1);
      chk("t5_mem_wdata", 64'(mem_wdata), 64'h55);
      @(posedge clk);
      #1;
    end
    wait_valid(1'b0, "t5_d_valid");
    d_req = 1'b0;
    d_wr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random mixed traffic
    use_force = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rand_step(1'b1);
    end
    for (int i = 0; i < 3000 && (if_req || d_req); i++) begin
      @(posedge clk);
      #1;
      rand_step(1'b0);
    end
    chk("drain_reqs", 64'({if_req, d_req}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a fetch
    model_en = 1'b0;
    resp_en  = 1'b0;
    exp_q.delete();
    if_addr  = 32'h500;
    if_req   = 1'b1;
    wait_mem_req("t6_mem_req");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_mem_req_async", 64'(mem_req), 64'd0);
    chk("t6_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    rst    = 1'b0;
    stray_pend = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid || d_valid || acc_err) nvalid++;
    end
    chk("t6_no_valid", 64'(nvalid), 64'd0);
    chk("t6_mem_req_idle", 64'(mem_req), 64'd0);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_if", 64'(perf_if_grants), 64'd0);
    chk("t6_perf_d", 64'(perf_d_grants), 64'd0);
    chk("t6_perf_to", 64'(perf_timeouts), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
